// File: rtl/exec_cc_stage.sv
// rtl/exec_cc_stage.sv - Y86-64 execute back end: condition codes, Cnd evaluation, E->M pipeline register
module exec_cc_stage #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_icode,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_vale,
    input  logic         in_of,
    input  logic [W-1:0] in_vala,
    input  logic [3:0]   in_dste,
    input  logic [3:0]   in_dstm,
    input  logic         cc_hold,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_icode,
    output logic [3:0]   out_ifun,
    output logic [W-1:0] out_vale,
    output logic [W-1:0] out_vala,
    output logic         out_cnd,
    output logic [3:0]   out_dste,
    output logic [3:0]   out_dstm,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of,
    output logic         halted
);

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_CMOV = 4'h2;
    localparam logic [3:0] ICODE_OPQ  = 4'h6;
    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] REG_NONE   = 4'hF;

    // State registers
    logic         out_valid_q, out_valid_d;
    logic [3:0]   out_icode_q, out_icode_d;
    logic [3:0]   out_ifun_q,  out_ifun_d;
    logic [W-1:0] out_vale_q,  out_vale_d;
    logic [W-1:0] out_vala_q,  out_vala_d;
    logic         out_cnd_q,   out_cnd_d;
    logic [3:0]   out_dste_q,  out_dste_d;
    logic [3:0]   out_dstm_q,  out_dstm_d;
    logic         cc_zf_q, cc_zf_d;
    logic         cc_sf_q, cc_sf_d;
    logic         cc_of_q, cc_of_d;
    logic         halted_q, halted_d;

    logic         acc;
    logic         cond_eval;
    logic         cnd;
    logic         cc_update;

    // Branch/cmov condition from the CC as it stands before this instruction updates it
    always_comb begin
        cond_eval = 1'b0;
        unique case (in_ifun)
            4'd0:    cond_eval = 1'b1;
            4'd1:    cond_eval = (cc_sf_q ^ cc_of_q) | cc_zf_q;
            4'd2:    cond_eval = cc_sf_q ^ cc_of_q;
            4'd3:    cond_eval = cc_zf_q;
            4'd4:    cond_eval = ~cc_zf_q;
            4'd5:    cond_eval = ~(cc_sf_q ^ cc_of_q);
            4'd6:    cond_eval = ~(cc_sf_q ^ cc_of_q) & ~cc_zf_q;
            default: cond_eval = 1'b0;
        endcase
        cnd = ((in_icode == ICODE_CMOV) || (in_icode == ICODE_JXX)) ? cond_eval : 1'b0;
    end

    // Handshake: stall while halted, in reset, or while a held result is not being consumed
    always_comb begin
        in_ready  = rst_n & ~halted_q & (~out_valid_q | out_ready);
        acc       = in_valid & in_ready;
        cc_update = acc & (in_icode == ICODE_OPQ) & ~cc_hold;
    end

    // Next-state for the pipeline register, condition codes and halt latch
    always_comb begin
        out_valid_d = out_valid_q;
        out_icode_d = out_icode_q;
        out_ifun_d  = out_ifun_q;
        out_vale_d  = out_vale_q;
        out_vala_d  = out_vala_q;
        out_cnd_d   = out_cnd_q;
        out_dste_d  = out_dste_q;
        out_dstm_d  = out_dstm_q;
        cc_zf_d     = cc_zf_q;
        cc_sf_d     = cc_sf_q;
        cc_of_d     = cc_of_q;
        halted_d    = halted_q;

        if (acc) begin
            out_valid_d = 1'b1;
            out_icode_d = in_icode;
            out_ifun_d  = in_ifun;
            out_vale_d  = in_vale;
            out_vala_d  = in_vala;
            out_cnd_d   = cnd;
            out_dstm_d  = in_dstm;
            // A cmov whose condition fails must not write its destination
            out_dste_d  = ((in_icode == ICODE_CMOV) && !cnd) ? REG_NONE : in_dste;
            if (in_icode == ICODE_HALT) begin
                halted_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (cc_update) begin
            cc_zf_d = (in_vale == '0);
            cc_sf_d = in_vale[W-1];
            cc_of_d = in_of;
        end
    end

    // State update with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_icode_q <= 4'h0;
            out_ifun_q  <= 4'h0;
            out_vale_q  <= '0;
            out_vala_q  <= '0;
            out_cnd_q   <= 1'b0;
            out_dste_q  <= REG_NONE;
            out_dstm_q  <= REG_NONE;
            cc_zf_q     <= 1'b1;
            cc_sf_q     <= 1'b0;
            cc_of_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_icode_q <= out_icode_d;
            out_ifun_q  <= out_ifun_d;
            out_vale_q  <= out_vale_d;
            out_vala_q  <= out_vala_d;
            out_cnd_q   <= out_cnd_d;
            out_dste_q  <= out_dste_d;
            out_dstm_q  <= out_dstm_d;
            cc_zf_q     <= cc_zf_d;
            cc_sf_q     <= cc_sf_d;
            cc_of_q     <= cc_of_d;
            halted_q    <= halted_d;
        end
    end

    // Registered outputs
    always_comb begin
        out_valid = out_valid_q;
        out_icode = out_icode_q;
        out_ifun  = out_ifun_q;
        out_vale  = out_vale_q;
        out_vala  = out_vala_q;
        out_cnd   = out_cnd_q;
        out_dste  = out_dste_q;
        out_dstm  = out_dstm_q;
        cc_zf     = cc_zf_q;
        cc_sf     = cc_sf_q;
        cc_of     = cc_of_q;
        halted    = halted_q;
    end

endmodule
